// File: rtl/stage_sequencer_pkg.sv
// Shared types and default constants for the multi-cycle stage sequencer.
package stage_sequencer_pkg;

    localparam int unsigned WORD_W = 32;

    localparam logic [WORD_W-1:0] DEFAULT_START_ADDRESS  = 32'h8002_0000;
    localparam logic [WORD_W-1:0] DEFAULT_MAIN_RTRN_ADDR = 32'h7777_7777;
    localparam logic [WORD_W-1:0] LOAD_STRIDE            = 32'd4;

    typedef enum logic [2:0] {
        ST_LOAD      = 3'd0,
        ST_FETCH     = 3'd1,
        ST_DECODE    = 3'd2,
        ST_EXECUTE   = 3'd3,
        ST_MEMORY    = 3'd4,
        ST_WRITEBACK = 3'd5,
        ST_HALT      = 3'd6
    } seq_state_t;

    // Write-enable bits of the decoded control word, captured in EXECUTE.
    typedef struct packed {
        logic dmwe;
        logic rwe;
    } ctl_flags_t;

    // True for the states that make up an instruction (cycle counter runs there).
    function automatic logic is_insn_state(input seq_state_t s);
        return (s == ST_FETCH) || (s == ST_DECODE) || (s == ST_EXECUTE) ||
               (s == ST_MEMORY) || (s == ST_WRITEBACK);
    endfunction

endpackage

// File: rtl/stage_sequencer_sat_counter32.sv
// 32-bit up counter that sticks at all-ones; cleared asynchronously by reset.
module sat_counter32
    import stage_sequencer_pkg::*;
(
    input  logic              clock,
    input  logic              reset,
    input  logic              enable,
    output logic [WORD_W-1:0] count
);

    logic [WORD_W-1:0] count_q;

    // Count up when enabled, holding once the maximum value is reached.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else if (enable && (count_q != {WORD_W{1'b1}})) begin
            count_q <= count_q + WORD_W'(1);
        end
    end

    assign count = count_q;

endmodule

// File: rtl/stage_sequencer.sv
// Multi-cycle control sequencer: image load, then FETCH..WRITEBACK per instruction until the return PC.
module stage_sequencer
    import stage_sequencer_pkg::*;
#(
    parameter logic [WORD_W-1:0] START_ADDRESS  = DEFAULT_START_ADDRESS,
    parameter logic [WORD_W-1:0] MAIN_RTRN_ADDR = DEFAULT_MAIN_RTRN_ADDR
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              load_valid,
    input  logic              load_last,
    input  logic [WORD_W-1:0] pc_fetch,
    input  logic              insn_busy,
    input  logic              data_busy,
    input  logic              ctl_dmwe,
    input  logic              ctl_rwe,
    output logic [WORD_W-1:0] load_addr,
    output logic              load_wren,
    output logic              stall,
    output logic              latch_if,
    output logic              latch_id,
    output logic              latch_ex,
    output logic              latch_mem,
    output logic              valid_insn,
    output logic              valid_ex,
    output logic              dm_wren,
    output logic              rf_wren,
    output logic              halted,
    output logic [WORD_W-1:0] insn_count,
    output logic [WORD_W-1:0] cycle_count
);

    seq_state_t        state_q;
    seq_state_t        state_d;
    logic [WORD_W-1:0] load_addr_q;
    ctl_flags_t        flags_q;
    logic              insn_done;

    // State register; reset abandons any instruction and restarts the image load.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= ST_LOAD;
        end else begin
            state_q <= state_d;
        end
    end

    // Load address steps one word after every accepted loader beat.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            load_addr_q <= START_ADDRESS;
        end else if ((state_q == ST_LOAD) && load_valid) begin
            load_addr_q <= load_addr_q + LOAD_STRIDE;
        end
    end

    // Capture the write enables of the decoded word for use in MEMORY/WRITEBACK.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            flags_q <= '0;
        end else if (state_q == ST_EXECUTE) begin
            flags_q <= '{dmwe: ctl_dmwe, rwe: ctl_rwe};
        end
    end

    // Next-state and per-state strobe decode.
    always_comb begin
        state_d    = state_q;
        load_wren  = 1'b0;
        stall      = 1'b1;
        latch_if   = 1'b0;
        latch_id   = 1'b0;
        latch_ex   = 1'b0;
        latch_mem  = 1'b0;
        valid_insn = 1'b0;
        valid_ex   = 1'b0;
        dm_wren    = 1'b0;
        rf_wren    = 1'b0;
        halted     = 1'b0;
        insn_done  = 1'b0;
        case (state_q)
            ST_LOAD: begin
                load_wren = load_valid;
                if (load_valid && load_last) begin
                    state_d = ST_FETCH;
                end
            end
            ST_FETCH: begin
                // The return-address check wins even when the instruction memory is busy.
                if (pc_fetch == MAIN_RTRN_ADDR) begin
                    state_d = ST_HALT;
                end else if (!insn_busy) begin
                    latch_if = 1'b1;
                    state_d  = ST_DECODE;
                end
            end
            ST_DECODE: begin
                valid_insn = 1'b1;
                latch_id   = 1'b1;
                state_d    = ST_EXECUTE;
            end
            ST_EXECUTE: begin
                valid_ex = 1'b1;
                latch_ex = 1'b1;
                state_d  = ST_MEMORY;
            end
            ST_MEMORY: begin
                dm_wren = flags_q.dmwe;
                if (!data_busy) begin
                    latch_mem = 1'b1;
                    state_d   = ST_WRITEBACK;
                end
            end
            ST_WRITEBACK: begin
                rf_wren   = flags_q.rwe;
                stall     = 1'b0;
                insn_done = 1'b1;
                state_d   = ST_FETCH;
            end
            ST_HALT: begin
                halted = 1'b1;
            end
            default: begin
                state_d = ST_LOAD;
            end
        endcase
    end

    assign load_addr = load_addr_q;

    // Retired-instruction counter.
    sat_counter32 u_insn_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (insn_done),
        .count  (insn_count)
    );

    // Active-cycle counter, running only while an instruction is in flight.
    sat_counter32 u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .enable (is_insn_state(state_q)),
        .count  (cycle_count)
    );

endmodule

// File: tb/tb_stage_sequencer.sv
// Directed bench for stage_sequencer with a load-address scoreboard and strobe tallies.
module tb_stage_sequencer;

    localparam logic [31:0] START = 32'h8002_0000;
    localparam logic [31:0] RTRN  = 32'h7777_7777;

    logic        clock = 1'b0;
    logic        reset;
    logic        load_valid, load_last;
    logic [31:0] pc_fetch;
    logic        insn_busy, data_busy, ctl_dmwe, ctl_rwe;
    logic [31:0] load_addr;
    logic        load_wren, stall, latch_if, latch_id, latch_ex, latch_mem;
    logic        valid_insn, valid_ex, dm_wren, rf_wren, halted;
    logic [31:0] insn_count, cycle_count;

    int total = 0;
    int bad   = 0;
    int dm_cnt = 0, rf_cnt = 0, lm_cnt = 0, sl_cnt = 0;
    logic [31:0] exp_q[$];

    stage_sequencer dut (
        .clock       (clock),
        .reset       (reset),
        .load_valid  (load_valid),
        .load_last   (load_last),
        .pc_fetch    (pc_fetch),
        .insn_busy   (insn_busy),
        .data_busy   (data_busy),
        .ctl_dmwe    (ctl_dmwe),
        .ctl_rwe     (ctl_rwe),
        .load_addr   (load_addr),
        .load_wren   (load_wren),
        .stall       (stall),
        .latch_if    (latch_if),
        .latch_id    (latch_id),
        .latch_ex    (latch_ex),
        .latch_mem   (latch_mem),
        .valid_insn  (valid_insn),
        .valid_ex    (valid_ex),
        .dm_wren     (dm_wren),
        .rf_wren     (rf_wren),
        .halted      (halted),
        .insn_count  (insn_count),
        .cycle_count (cycle_count)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Scoreboard for loader writes plus tallies of strobe cycles, sampled mid-low-phase.
    always @(negedge clock) begin
        #2;
        if (load_wren === 1'b1) begin
            if (exp_q.size() == 0) begin
                total++;
                bad++;
                $error("FAIL load_unexpected: observed=%h expected=none", load_addr);
            end else begin
                check("load_addr_beat", load_addr, exp_q.pop_front());
            end
        end
        if (dm_wren === 1'b1)   dm_cnt++;
        if (rf_wren === 1'b1)   rf_cnt++;
        if (latch_mem === 1'b1) lm_cnt++;
        if (stall === 1'b0)     sl_cnt++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // Run one instruction from a FETCH cycle; report latency and strobe tallies.
    task automatic run_insn(input int busy, output int lat, output int dm, output int rf,
                            output int lm, output int sl);
        int dm0 = dm_cnt, rf0 = rf_cnt, lm0 = lm_cnt, sl0 = sl_cnt;
        lat = 0;
        for (int i = 1; i <= 30; i++) begin
            @(negedge clock);
            data_busy = (i >= 3) && (i < 3 + busy);
            #1;
            if (i == 1) begin
                check("decode_valid_insn", 32'(valid_insn), 32'd1);
                check("decode_latch_id", 32'(latch_id), 32'd1);
            end
            if (i == 2) begin
                check("exec_valid_ex", 32'(valid_ex), 32'd1);
                check("exec_latch_ex", 32'(latch_ex), 32'd1);
            end
            if (latch_if === 1'b1) begin
                lat = i;
                break;
            end
        end
        dm = dm_cnt - dm0;
        rf = rf_cnt - rf0;
        lm = lm_cnt - lm0;
        sl = sl_cnt - sl0;
    endtask

    initial begin
        int lat, dm, rf, lm, sl, rf_snap;
        reset = 1'b1; load_valid = 0; load_last = 0; pc_fetch = 32'h1000;
        insn_busy = 0; data_busy = 0; ctl_dmwe = 0; ctl_rwe = 0;

        // Reset state
        @(negedge clock); #1;
        check("rst_load_addr", load_addr, START);
        check("rst_stall", 32'(stall), 32'd1);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_load_wren", 32'(load_wren), 32'd0);
        check("rst_cycle_count", cycle_count, 32'd0);
        check("rst_insn_count", insn_count, 32'd0);

        // Three-beat image load
        @(negedge clock); reset = 1'b0;
        for (int b = 0; b < 3; b++) begin
            @(negedge clock);
            load_valid = 1'b1;
            load_last  = (b == 2);
            exp_q.push_back(START + 32'(4 * b));
        end
        @(negedge clock);
        load_valid = 0; load_last = 0; ctl_dmwe = 1; ctl_rwe = 0;
        #1;
        check("load_q_drained", 32'(exp_q.size()), 32'd0);
        check("load_addr_end", load_addr, 32'h8002_000C);
        check("fetch_latch_if", 32'(latch_if), 32'd1);
        check("fetch_stall", 32'(stall), 32'd1);

        // Store-only instruction, no busy
        run_insn(0, lat, dm, rf, lm, sl);
        check("i1_latency", 32'(lat), 32'd5);
        check("i1_dm_cycles", 32'(dm), 32'd1);
        check("i1_rf_cycles", 32'(rf), 32'd0);
        check("i1_latch_mem", 32'(lm), 32'd1);
        check("i1_stall_low", 32'(sl), 32'd1);
        check("i1_insn_count", insn_count, 32'd1);
        check("i1_cycle_count", cycle_count, 32'd5);

        // Store + register write with data memory busy for three cycles
        ctl_dmwe = 1; ctl_rwe = 1;
        run_insn(3, lat, dm, rf, lm, sl);
        check("i2_latency", 32'(lat), 32'd8);
        check("i2_dm_cycles", 32'(dm), 32'd4);
        check("i2_rf_cycles", 32'(rf), 32'd1);
        check("i2_latch_mem", 32'(lm), 32'd1);
        check("i2_stall_low", 32'(sl), 32'd1);
        check("i2_insn_count", insn_count, 32'd2);
        check("i2_cycle_count", cycle_count, 32'd13);

        // Return PC while instruction memory busy -> halt
        pc_fetch = RTRN; insn_busy = 1;
        #1;
        check("halt_no_latch_if", 32'(latch_if), 32'd0);
        @(negedge clock); #1;
        check("halt_halted", 32'(halted), 32'd1);
        check("halt_stall", 32'(stall), 32'd1);
        check("halt_cycle_count", cycle_count, 32'd14);
        insn_busy = 0; pc_fetch = 32'h1000;
        repeat (3) @(negedge clock);
        #1;
        check("halt_sticky", 32'(halted), 32'd1);
        check("halt_cycle_frozen", cycle_count, 32'd14);
        check("halt_insn_frozen", insn_count, 32'd2);
        check("halt_latch_if", 32'(latch_if), 32'd0);

        // Reset out of HALT, reload one word, then reset during MEMORY
        reset = 1'b1; #1;
        check("rst2_halted", 32'(halted), 32'd0);
        check("rst2_load_addr", load_addr, START);
        @(negedge clock); reset = 1'b0;
        @(negedge clock); load_valid = 1; load_last = 1; exp_q.push_back(START);
        @(negedge clock); load_valid = 0; load_last = 0;
        pc_fetch = 32'h2000; ctl_dmwe = 1; ctl_rwe = 1; data_busy = 1;
        repeat (3) @(negedge clock);
        #1;
        check("mem_dm_wren", 32'(dm_wren), 32'd1);
        #2; reset = 1'b1; #1;
        check("rstmem_dm_wren", 32'(dm_wren), 32'd0);
        check("rstmem_rf_wren", 32'(rf_wren), 32'd0);
        check("rstmem_load_addr", load_addr, START);
        check("rstmem_cycle_count", cycle_count, 32'd0);
        check("rstmem_insn_count", insn_count, 32'd0);
        rf_snap = rf_cnt;
        @(negedge clock); reset = 1'b0; data_busy = 0;
        repeat (3) @(negedge clock);
        #3;
        check("rstmem_no_rf_pulse", 32'(rf_cnt - rf_snap), 32'd0);
        check("rstmem_in_load_stall", 32'(stall), 32'd1);

        // Cycle counter saturation while FETCH is held by insn_busy
        @(negedge clock); load_valid = 1; load_last = 1; exp_q.push_back(START);
        @(negedge clock); load_valid = 0; load_last = 0; insn_busy = 1; pc_fetch = 32'h3000;
        #1;
        force dut.u_cycle_cnt.count_q = 32'hFFFF_FFFE;
        #1;
        release dut.u_cycle_cnt.count_q;
        #1;
        check("sat_preload", cycle_count, 32'hFFFF_FFFE);
        repeat (3) @(negedge clock);
        #1;
        check("sat_cycle_count", cycle_count, 32'hFFFF_FFFF);
        check("sat_fetch_hold", 32'(latch_if), 32'd0);
        check("sat_load_q_drained", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
